// File: rtl/tile_map_arbiter_if.sv
// Bus between the tile map arbiter and its clients: display read port,
// two tile-write requesters and a debug view of the write FSM state.
interface tile_map_arbiter_if #(
  parameter int TW = 4
);
  logic [3:0]    rd_i;
  logic [3:0]    rd_j;
  logic [TW-1:0] rd_tile;
  logic          rd_valid;

  // 4-phase handshake: reqN rises with wiN/wjN/wtN/condN stable and stays high
  // until ackN is seen; ackN then stays high (with ok stable) until reqN falls.
  logic          req0;
  logic          req1;
  logic [3:0]    wi0;
  logic [3:0]    wj0;
  logic [3:0]    wi1;
  logic [3:0]    wj1;
  logic [TW-1:0] wt0;
  logic [TW-1:0] wt1;
  logic          cond0;
  logic          cond1;
  logic          ack0;
  logic          ack1;
  logic          ok;
  logic          busy;
  logic [1:0]    dbg_state;

  modport master (
    output rd_i, rd_j, req0, req1, wi0, wj0, wi1, wj1, wt0, wt1, cond0, cond1,
    input  rd_tile, rd_valid, ack0, ack1, ok, busy, dbg_state
  );

  modport slave (
    input  rd_i, rd_j, req0, req1, wi0, wj0, wi1, wj1, wt0, wt1, cond0, cond1,
    output rd_tile, rd_valid, ack0, ack1, ok, busy, dbg_state
  );
endinterface

// File: rtl/tile_map_arbiter.sv
// Playfield tile map with a free-running display read port and a round-robin
// arbitrated, optionally conditional, write port for two requesters.
module tile_map_arbiter #(
  parameter int ROWS = 9,
  parameter int COLS = 12,
  parameter int TW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  tile_map_arbiter_if.slave bus
);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  function automatic logic in_map(input logic [3:0] i, input logic [3:0] j);
    return (i != 4'd0) && (int'(i) <= ROWS) && (j != 4'd0) && (int'(j) <= COLS);
  endfunction

  // Out-of-range indices map to address 0; callers gate every use with in_map.
  function automatic logic [AW-1:0] cell_addr(input logic [3:0] i, input logic [3:0] j);
    int a;
    a = 0;
    if (in_map(i, j)) a = (int'(i) - 1) * COLS + (int'(j) - 1);
    return a[AW-1:0];
  endfunction

  logic [TW-1:0] map_q [CELLS];

  logic          rd_in;
  logic [AW-1:0] rd_addr;
  logic [TW-1:0] rd_tile_q;
  logic          rd_valid_q;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic          gid_q, gid_d;
  logic [3:0]    wi_q, wi_d;
  logic [3:0]    wj_q, wj_d;
  logic [TW-1:0] wt_q, wt_d;
  logic          cond_q, cond_d;
  logic          ok_q, ok_d;
  logic [1:0]    ack_q, ack_d;

  logic          pick;
  logic          held;
  logic          ex_in;
  logic [AW-1:0] ex_addr;
  logic          pass;
  logic          we;

  always_comb begin
    rd_in   = in_map(bus.rd_i, bus.rd_j);
    rd_addr = cell_addr(bus.rd_i, bus.rd_j);
  end

  // The read samples map_q before any same-edge write lands, so it sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_tile_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_tile_q  <= rd_in ? map_q[rd_addr] : '0;
      rd_valid_q <= rd_in;
    end
  end

  always_comb begin
    ex_in   = in_map(wi_q, wj_q);
    ex_addr = cell_addr(wi_q, wj_q);
    pass    = ex_in && (!cond_q || (map_q[ex_addr] == '0));
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gid_d   = gid_q;
    wi_d    = wi_q;
    wj_d    = wj_q;
    wt_d    = wt_q;
    cond_d  = cond_q;
    ok_d    = ok_q;
    ack_d   = ack_q;
    pick    = 1'b0;
    held    = 1'b0;
    we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          pick    = (bus.req0 && bus.req1) ? prio_q : bus.req1;
          gid_d   = pick;
          wi_d    = pick ? bus.wi1 : bus.wi0;
          wj_d    = pick ? bus.wj1 : bus.wj0;
          wt_d    = pick ? bus.wt1 : bus.wt0;
          cond_d  = pick ? bus.cond1 : bus.cond0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        we      = pass;
        ok_d    = pass;
        ack_d   = gid_q ? 2'b10 : 2'b01;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        held = gid_q ? bus.req1 : bus.req0;
        if (!held) begin
          ack_d   = 2'b00;
          prio_d  = ~gid_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      gid_q   <= 1'b0;
      wi_q    <= '0;
      wj_q    <= '0;
      wt_q    <= '0;
      cond_q  <= 1'b0;
      ok_q    <= 1'b0;
      ack_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gid_q   <= gid_d;
      wi_q    <= wi_d;
      wj_q    <= wj_d;
      wt_q    <= wt_d;
      cond_q  <= cond_d;
      ok_q    <= ok_d;
      ack_q   <= ack_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CELLS; k++) map_q[k] <= '0;
    end else if (we) begin
      map_q[ex_addr] <= wt_q;
    end
  end

  assign bus.rd_tile   = rd_tile_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.ack0      = ack_q[0];
  assign bus.ack1      = ack_q[1];
  assign bus.ok        = ok_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.dbg_state = state_q;
endmodule
